// File: rtl/kinase_ctrl_pkg.sv
// Shared types and helpers for the kinase assay valve controller.
// Pump patterns are built on a fixed-width vector and sliced by the user.
package kinase_ctrl_pkg;

  typedef enum logic [2:0] {StIdle, StLoad, StMix, StFlush, StDone} state_e;

  localparam int unsigned MaxValves     = 32;
  localparam int unsigned DefPumpValves = 3;

  // One full rotation visits each valve alone and then paired with its successor.
  function automatic int unsigned phase_count(input int unsigned n);
    return 2 * n;
  endfunction

  function automatic logic [MaxValves-1:0] pump_pattern(input int unsigned phase,
                                                        input int unsigned n);
    int unsigned           k;
    logic [MaxValves-1:0]  v;
    k = phase / 2;
    v = MaxValves'(1) << k;
    if (phase[0]) v = v | (MaxValves'(1) << ((k + 1) % n));
    return v;
  endfunction

endpackage

// File: rtl/peristaltic_phase_gen.sv
// Peristaltic pump sequencer: phase, dwell and rotation counters with a
// registered valve pattern (all valves closed whenever not running).
module peristaltic_phase_gen
  import kinase_ctrl_pkg::*;
#(
  parameter int unsigned PUMP_VALVES = DefPumpValves,
  parameter int unsigned TICK_W      = 16,
  parameter int unsigned CYC_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   en_i,
  input  logic [TICK_W-1:0]      dwell_i,
  input  logic [CYC_W-1:0]       rotations_i,
  output logic [PUMP_VALVES-1:0] pattern_o,
  output logic                   rot_done_o
);

  localparam int unsigned Phases = phase_count(PUMP_VALVES);
  localparam int unsigned PhaseW = $clog2(Phases);

  logic [PhaseW-1:0]      phase_q, phase_d;
  logic [TICK_W-1:0]      dwell_q, dwell_d, dwell_m1;
  logic [CYC_W-1:0]       rot_q, rot_d;
  logic [PUMP_VALVES-1:0] pattern_q, pattern_d;
  logic [MaxValves-1:0]   pat_full;
  logic                   last_phase;

  assign dwell_m1   = (dwell_i == '0) ? '0 : dwell_i - TICK_W'(1);
  assign last_phase = (phase_q == PhaseW'(Phases - 1));
  // High during the final clock of the final rotation.
  assign rot_done_o = (rot_q == CYC_W'(1)) && last_phase && (dwell_q == '0);
  assign pattern_o  = pattern_q;

  always_comb begin
    phase_d = phase_q;
    dwell_d = dwell_q;
    rot_d   = rot_q;
    if (start_i) begin
      phase_d = '0;
      dwell_d = dwell_m1;
      rot_d   = rotations_i;
    end else if (en_i) begin
      if (dwell_q != '0) begin
        dwell_d = dwell_q - TICK_W'(1);
      end else begin
        dwell_d = dwell_m1;
        if (last_phase) begin
          phase_d = '0;
          rot_d   = rot_q - CYC_W'(1);
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
    end
    pat_full  = pump_pattern(32'(phase_d), PUMP_VALVES);
    pattern_d = (start_i || en_i) ? pat_full[PUMP_VALVES-1:0] : '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      dwell_q   <= '0;
      rot_q     <= '0;
      pattern_q <= '1;
    end else begin
      phase_q   <= phase_d;
      dwell_q   <= dwell_d;
      rot_q     <= rot_d;
      pattern_q <= pattern_d;
    end
  end

endmodule

// File: rtl/kinase_array_ctrl.sv
// Kinase assay array valve controller: accepts a command, then runs a timed
// LOAD -> MIX -> FLUSH sequence with abort; every output is registered.
module kinase_array_ctrl
  import kinase_ctrl_pkg::*;
#(
  parameter int unsigned CHANNELS    = 6,
  parameter int unsigned PUMP_VALVES = DefPumpValves,
  parameter int unsigned TICK_W      = 16,
  parameter int unsigned CYC_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [CHANNELS-1:0]    cmd_mask_i,
  input  logic [CYC_W-1:0]       cmd_cycles_i,
  input  logic                   cmd_flush_i,
  input  logic [TICK_W-1:0]      cfg_load_i,
  input  logic [TICK_W-1:0]      cfg_dwell_i,
  input  logic [TICK_W-1:0]      cfg_flush_i,
  input  logic                   abort_i,
  output logic [CHANNELS-1:0]    ctrl_in_o,
  output logic [CHANNELS-1:0]    ctrl_out_o,
  output logic [PUMP_VALVES-1:0] pump_o,
  output logic [CHANNELS-1:0]    flush_en_o,
  output logic                   busy_o,
  output logic                   done_o
);

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CYC_W-1:0]    cycles_q;
  logic                flush_q;
  logic [TICK_W-1:0]   dwell_q, flush_m1_q, tick_q, tick_d;
  logic                cmd_ready_q, busy_q, done_q;
  logic [CHANNELS-1:0] ctrl_in_q, ctrl_out_q, flush_en_q;
  logic                accept, mix_start, mix_en, rot_done;

  assign accept    = cmd_valid_i && cmd_ready_q;
  assign mask_d    = accept ? cmd_mask_i : mask_q;
  assign mix_start = (state_q == StLoad) && (state_d == StMix);
  assign mix_en    = (state_q == StMix) && (state_d == StMix);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StLoad;
      StLoad: begin
        if (abort_i)               state_d = StFlush;
        else if (tick_q == '0) begin
          if (cycles_q != '0)      state_d = StMix;
          else if (flush_q)        state_d = StFlush;
          else                     state_d = StDone;
        end
      end
      StMix: begin
        if (abort_i)               state_d = StFlush;
        else if (rot_done)         state_d = flush_q ? StFlush : StDone;
      end
      StFlush: if (tick_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // One shared down-counter times both LOAD and FLUSH; it is reloaded on entry.
  always_comb begin
    tick_d = tick_q;
    if (accept) begin
      tick_d = (cfg_load_i == '0) ? '0 : cfg_load_i - TICK_W'(1);
    end else if ((state_d == StFlush) && (state_q != StFlush)) begin
      tick_d = flush_m1_q;
    end else if (tick_q != '0) begin
      tick_d = tick_q - TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      cycles_q    <= '0;
      flush_q     <= 1'b0;
      dwell_q     <= '0;
      flush_m1_q  <= '0;
      tick_q      <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ctrl_in_q   <= '0;
      ctrl_out_q  <= '0;
      flush_en_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      mask_q  <= mask_d;
      if (accept) begin
        cycles_q   <= cmd_cycles_i;
        flush_q    <= cmd_flush_i;
        dwell_q    <= cfg_dwell_i;
        flush_m1_q <= (cfg_flush_i == '0) ? '0 : cfg_flush_i - TICK_W'(1);
      end
      cmd_ready_q <= (state_d == StIdle);
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StDone);
      ctrl_in_q   <= (state_d == StLoad) ? mask_d : '0;
      ctrl_out_q  <= (state_d == StFlush) ? mask_d : '0;
      flush_en_q  <= (state_d == StFlush) ? mask_d : '0;
    end
  end

  peristaltic_phase_gen #(
    .PUMP_VALVES (PUMP_VALVES),
    .TICK_W      (TICK_W),
    .CYC_W       (CYC_W)
  ) u_phase_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (mix_start),
    .en_i        (mix_en),
    .dwell_i     (dwell_q),
    .rotations_i (cycles_q),
    .pattern_o   (pump_o),
    .rot_done_o  (rot_done)
  );

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign ctrl_in_o   = ctrl_in_q;
  assign ctrl_out_o  = ctrl_out_q;
  assign flush_en_o  = flush_en_q;

endmodule
